pocket_detector: RTL and testbench
==================================

Name: pocket_detector

Overview:
- Sits directly downstream of the hole bitmap drawers and the ball drawers. It consumes their per-pixel drawing requests.
- Each frame, counts the pixels where a ball and a hole are drawn together. At the frame boundary, declares each ball pocketed or not.
- Keeps a sticky pocketed mask, a pocketed-ball count, and a cue-ball scratch indication for the game controller.

Parameters:
- NUM_BALLS, 8, number of ball drawing-request inputs; legal range 2..15.
- CUE_INDEX, 0, index of the cue ball within drawingRequestBall.
- OVERLAP_THRESHOLD, 64, overlapping pixels per frame at which a ball counts as pocketed.
- CNT_W, 10, width of each per-ball overlap counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- drawingRequestHole  in  1  OR of all hole drawing requests for the current pixel.
- drawingRequestBall  in  NUM_BALLS  per-ball drawing request for the current pixel.
- clearMask  in  1  one-cycle pulse that starts a new game; clears mask, count and allPocketed.
- pocketed  out  NUM_BALLS  one-cycle pulse per newly pocketed object ball.
- pocketedMask  out  NUM_BALLS  sticky record of pocketed object balls.
- scratch  out  1  one-cycle pulse when the cue ball is detected in a hole.
- pocketCount  out  4  number of set bits in pocketedMask.
- allPocketed  out  1  high while every non-cue bit of pocketedMask is set.

Behaviour:
- Reset: all outputs are 0, all counters are 0, FSM is in WAIT_SOF. Reset asserted mid-frame discards the partial frame.
- FSM states:
  - WAIT_SOF: ignore requests. On startOfFrame, go to ACCUM and load the counters from the current cycle's overlap (1 or 0).
  - ACCUM: each cycle where drawingRequestHole && drawingRequestBall[i], increment counter i. Counters saturate and never wrap. On startOfFrame, go to EVAL.
  - EVAL: one cycle, then return to ACCUM.
- Evaluation (registered on the startOfFrame cycle, visible in the EVAL cycle):
  - hit[i] = counter[i] >= OVERLAP_THRESHOLD, using the counter value before the startOfFrame cycle's pixel.
  - That startOfFrame cycle's overlap belongs to the new frame: counter[i] loads 1 if overlapping, else 0.
- Outputs in the EVAL cycle:
  - For i != CUE_INDEX with hit[i] and pocketedMask[i]==0: pocketed[i]=1 and pocketedMask[i] set.
  - For a ball already in the mask: no repeat pulse.
  - Cue ball hit: scratch=1. The cue ball is never set in the mask and is never counted.
  - pocketed and scratch are 0 in every non-EVAL cycle.
- Overlap during EVAL is counted normally into the new frame.
- pocketCount updates in the same cycle as pocketedMask and equals the popcount of the mask (4-bit, max 15).
- allPocketed is derived from the registered mask, so it updates with the mask.
- clearMask:
  - Clears pocketedMask, pocketCount and allPocketed next cycle. Overlap counters and FSM state are not affected.
  - If clearMask coincides with an EVAL update, clearMask wins: mask=0, but the pocketed/scratch pulses still fire.
- A pixel with drawingRequestHole=0 never counts, regardless of ball requests.
- Multiple balls may hit in the same frame; all their pulses fire in the same EVAL cycle.

Test Plan:
- Reset then first frame, with no startOfFrame seen yet: 100 overlap cycles on ball 3 before the first startOfFrame -> no pulse at the next boundary; all outputs 0.
- Ball 3 overlaps hole for exactly 64 cycles in a frame -> pocketed=8'h08 for one cycle after the next startOfFrame; pocketedMask=8'h08; pocketCount=1. Same frame with 63 cycles -> no pulse.
- Ball 3 keeps overlapping for 3 more frames -> no further pocketed pulses; mask stays 8'h08. Ball 0 overlaps 200 cycles -> scratch pulse only; mask unchanged; count unchanged.
- Balls 1..7 all exceed threshold in one frame -> pocketed=8'hFE in one cycle; pocketCount=7; allPocketed=1. Then clearMask -> mask 0, count 0, allPocketed 0 next cycle.
- Counter saturation: ball 2 overlaps 2000 cycles -> counter holds at 1023; one pocketed pulse.
- Boundary pixel: overlap exactly on the startOfFrame cycle after 63 prior cycles -> no hit that frame; new frame counter starts at 1. Reset asserted mid-frame -> outputs 0 immediately; FSM back in WAIT_SOF.

Source files
------------

// File: rtl/pocket_detector.sv
// Pocket detector: counts per-ball hole overlap pixels each frame and, at the
// frame boundary, reports newly pocketed object balls and cue-ball scratches.
module pocket_detector #(
  parameter int unsigned NUM_BALLS         = 8,
  parameter int unsigned CUE_INDEX         = 0,
  parameter int unsigned OVERLAP_THRESHOLD = 64,
  parameter int unsigned CNT_W             = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 drawingRequestHole,
  input  logic [NUM_BALLS-1:0] drawingRequestBall,
  input  logic                 clearMask,
  output logic [NUM_BALLS-1:0] pocketed,
  output logic [NUM_BALLS-1:0] pocketedMask,
  output logic                 scratch,
  output logic [3:0]           pocketCount,
  output logic                 allPocketed
);

  typedef enum logic [1:0] {StWaitSof, StAccum, StEval} state_e;

  localparam logic [CNT_W-1:0]     CntMax  = '1;
  localparam logic [NUM_BALLS-1:0] CueMask = NUM_BALLS'(1) << CUE_INDEX;

  state_e r_state, w_state_next;

  logic [CNT_W-1:0]     r_cnt [NUM_BALLS];
  logic [CNT_W-1:0]     w_cnt_next [NUM_BALLS];
  logic [NUM_BALLS-1:0] r_mask, w_mask_next;
  logic [NUM_BALLS-1:0] r_pocketed, w_new_pocket;
  logic                 r_scratch, w_scratch_next;
  logic [NUM_BALLS-1:0] w_overlap;
  logic [NUM_BALLS-1:0] w_hit;
  logic                 w_eval_now;
  logic [3:0]           w_count;

  assign w_overlap  = drawingRequestBall & {NUM_BALLS{drawingRequestHole}};
  // Evaluation only closes a frame that was fully accumulated.
  assign w_eval_now = (r_state == StAccum) && startOfFrame;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StWaitSof;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StWaitSof: if (startOfFrame) w_state_next = StAccum;
      StAccum:   if (startOfFrame) w_state_next = StEval;
      StEval:    w_state_next = StAccum;
      default:   w_state_next = StWaitSof;
    endcase
  end

  // Per-ball hit decision and counter next state; the boundary pixel seeds the new frame.
  always_comb begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      w_hit[i]      = 32'(r_cnt[i]) >= OVERLAP_THRESHOLD;
      w_cnt_next[i] = r_cnt[i];
      if (startOfFrame && (r_state != StEval)) begin
        w_cnt_next[i] = CNT_W'(w_overlap[i]);
      end else if ((r_state != StWaitSof) && w_overlap[i] && (r_cnt[i] != CntMax)) begin
        w_cnt_next[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  // Pulse and mask next state; clearMask overrides the mask update but not the pulses.
  always_comb begin
    w_new_pocket   = w_eval_now ? (w_hit & ~CueMask & ~r_mask) : '0;
    w_scratch_next = w_eval_now && w_hit[CUE_INDEX];
    w_mask_next    = clearMask ? '0 : (r_mask | w_new_pocket);
  end

  // Datapath registers: overlap counters, sticky mask and boundary pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BALLS; i++) r_cnt[i] <= '0;
      r_mask     <= '0;
      r_pocketed <= '0;
      r_scratch  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) r_cnt[i] <= w_cnt_next[i];
      r_mask     <= w_mask_next;
      r_pocketed <= w_new_pocket;
      r_scratch  <= w_scratch_next;
    end
  end

  // FSM outputs: pulses only in EVAL, mask-derived status otherwise.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_BALLS; i++) w_count = w_count + 4'(r_mask[i]);
    pocketed     = (r_state == StEval) ? r_pocketed : '0;
    scratch      = (r_state == StEval) && r_scratch;
    pocketedMask = r_mask;
    pocketCount  = w_count;
    allPocketed  = &(r_mask | CueMask);
  end

endmodule

// File: tb/tb_pocket_detector.sv
// Directed bench for pocket_detector with the default 8-ball configuration.
module tb_pocket_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       drawingRequestHole;
  logic [7:0] drawingRequestBall;
  logic       clearMask;
  logic [7:0] pocketed;
  logic [7:0] pocketedMask;
  logic       scratch;
  logic [3:0] pocketCount;
  logic       allPocketed;

  int n_checks = 0;
  int n_fail   = 0;

  pocket_detector dut (
    .clk                (clk),
    .reset              (reset),
    .startOfFrame       (startOfFrame),
    .drawingRequestHole (drawingRequestHole),
    .drawingRequestBall (drawingRequestBall),
    .clearMask          (clearMask),
    .pocketed           (pocketed),
    .pocketedMask       (pocketedMask),
    .scratch            (scratch),
    .pocketCount        (pocketCount),
    .allPocketed        (allPocketed)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic overlap(input logic [7:0] balls, input int n, input logic hole = 1'b1);
    drawingRequestHole = hole;
    drawingRequestBall = balls;
    repeat (n) tick();
    drawingRequestHole = 1'b0;
    drawingRequestBall = '0;
  endtask

  // One startOfFrame cycle; returns sampling the EVAL cycle.
  task automatic sof(input logic [7:0] balls = '0, input logic clr = 1'b0);
    startOfFrame       = 1'b1;
    drawingRequestHole = |balls;
    drawingRequestBall = balls;
    clearMask          = clr;
    tick();
    startOfFrame       = 1'b0;
    drawingRequestHole = 1'b0;
    drawingRequestBall = '0;
    clearMask          = 1'b0;
  endtask

  task automatic do_clear();
    clearMask = 1'b1;
    tick();
    clearMask = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (pocketed !== 8'h00) begin
      n_fail++; $display("FAIL reset_pocketed got %h want 00", pocketed);
    end
    n_checks++;
    if (pocketedMask !== 8'h00) begin
      n_fail++; $display("FAIL reset_mask got %h want 00", pocketedMask);
    end
    n_checks++;
    if ({scratch, pocketCount, allPocketed} !== 6'b0) begin
      n_fail++; $display("FAIL reset_status got s=%b c=%0d a=%b want 0 0 0",
                         scratch, pocketCount, allPocketed);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pre_sof();
    overlap(8'h08, 100);
    sof();
    n_checks++;
    if (pocketed !== 8'h00) begin
      n_fail++; $display("FAIL pre_sof_first got %h want 00", pocketed);
    end
    sof();
    n_checks++;
    if ({pocketed, pocketedMask} !== 16'h0000) begin
      n_fail++; $display("FAIL pre_sof_second got p=%h m=%h want 00 00", pocketed, pocketedMask);
    end
  endtask

  task automatic test_threshold();
    overlap(8'h08, 63);
    sof();
    n_checks++;
    if (pocketed !== 8'h00) begin
      n_fail++; $display("FAIL thresh_63 got %h want 00", pocketed);
    end
    overlap(8'h08, 64);
    sof();
    n_checks++;
    if (pocketed !== 8'h08) begin
      n_fail++; $display("FAIL thresh_64_pulse got %h want 08", pocketed);
    end
    n_checks++;
    if (pocketedMask !== 8'h08 || pocketCount !== 4'd1) begin
      n_fail++; $display("FAIL thresh_64_mask got m=%h c=%0d want 08 1", pocketedMask, pocketCount);
    end
    tick();
    n_checks++;
    if (pocketed !== 8'h00) begin
      n_fail++; $display("FAIL thresh_pulse_width got %h want 00", pocketed);
    end
  endtask

  task automatic test_no_repeat_scratch();
    for (int f = 0; f < 3; f++) begin
      overlap(8'h08, 100);
      sof();
      n_checks++;
      if (pocketed !== 8'h00 || pocketedMask !== 8'h08) begin
        n_fail++; $display("FAIL no_repeat_%0d got p=%h m=%h want 00 08", f, pocketed, pocketedMask);
      end
    end
    overlap(8'h01, 200);
    sof();
    n_checks++;
    if (scratch !== 1'b1 || pocketed !== 8'h00) begin
      n_fail++; $display("FAIL scratch_pulse got s=%b p=%h want 1 00", scratch, pocketed);
    end
    n_checks++;
    if (pocketedMask !== 8'h08 || pocketCount !== 4'd1) begin
      n_fail++; $display("FAIL scratch_mask got m=%h c=%0d want 08 1", pocketedMask, pocketCount);
    end
    tick();
    n_checks++;
    if (scratch !== 1'b0) begin
      n_fail++; $display("FAIL scratch_width got %b want 0", scratch);
    end
  endtask

  task automatic test_multi_and_clear();
    do_clear();
    n_checks++;
    if (pocketedMask !== 8'h00) begin
      n_fail++; $display("FAIL pre_multi_clear got %h want 00", pocketedMask);
    end
    overlap(8'hFE, 80);
    sof();
    n_checks++;
    if (pocketed !== 8'hFE) begin
      n_fail++; $display("FAIL multi_pulse got %h want fe", pocketed);
    end
    n_checks++;
    if (pocketedMask !== 8'hFE || pocketCount !== 4'd7 || allPocketed !== 1'b1) begin
      n_fail++; $display("FAIL multi_status got m=%h c=%0d a=%b want fe 7 1",
                         pocketedMask, pocketCount, allPocketed);
    end
    do_clear();
    n_checks++;
    if (pocketedMask !== 8'h00 || pocketCount !== 4'd0 || allPocketed !== 1'b0) begin
      n_fail++; $display("FAIL clear_status got m=%h c=%0d a=%b want 00 0 0",
                         pocketedMask, pocketCount, allPocketed);
    end
  endtask

  task automatic test_clear_vs_eval();
    overlap(8'h20, 70);
    sof(8'h00, 1'b1);
    n_checks++;
    if (pocketed !== 8'h20 || pocketedMask !== 8'h00) begin
      n_fail++; $display("FAIL clear_vs_eval got p=%h m=%h want 20 00", pocketed, pocketedMask);
    end
  endtask

  task automatic test_saturation();
    overlap(8'h04, 2000);
    n_checks++;
    if (dut.r_cnt[2] !== 10'd1023) begin
      n_fail++; $display("FAIL sat_hold got %0d want 1023", dut.r_cnt[2]);
    end
    sof();
    n_checks++;
    if (pocketed !== 8'h04) begin
      n_fail++; $display("FAIL sat_pulse got %h want 04", pocketed);
    end
    tick();
    n_checks++;
    if (pocketed !== 8'h00 || pocketedMask !== 8'h04) begin
      n_fail++; $display("FAIL sat_single got p=%h m=%h want 00 04", pocketed, pocketedMask);
    end
    // 1050 would wrap to 26 if the counter did not saturate.
    overlap(8'h10, 1050);
    sof();
    n_checks++;
    if (pocketed !== 8'h10) begin
      n_fail++; $display("FAIL sat_nowrap got %h want 10", pocketed);
    end
  endtask

  task automatic test_boundary();
    overlap(8'h40, 63);
    sof(8'h40);
    n_checks++;
    if (pocketed !== 8'h00) begin
      n_fail++; $display("FAIL boundary_old_frame got %h want 00", pocketed);
    end
    overlap(8'h40, 63);
    sof();
    n_checks++;
    if (pocketed !== 8'h40) begin
      n_fail++; $display("FAIL boundary_new_frame got %h want 40", pocketed);
    end
    overlap(8'h02, 100, 1'b0);
    sof();
    n_checks++;
    if (pocketed !== 8'h00) begin
      n_fail++; $display("FAIL no_hole got %h want 00", pocketed);
    end
  endtask

  task automatic test_reset_mid();
    overlap(8'h80, 50);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (pocketedMask !== 8'h00 || pocketCount !== 4'd0) begin
      n_fail++; $display("FAIL reset_mid_async got m=%h c=%0d want 00 0", pocketedMask, pocketCount);
    end
    tick();
    reset = 1'b0;
    tick();
    overlap(8'h80, 100);
    sof();
    n_checks++;
    if (pocketed !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_wait_sof got %h want 00", pocketed);
    end
    sof();
    n_checks++;
    if (pocketed !== 8'h00 || pocketedMask !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_empty got p=%h m=%h want 00 00", pocketed, pocketedMask);
    end
  endtask

  initial begin
    reset              = 1'b1;
    startOfFrame       = 1'b0;
    drawingRequestHole = 1'b0;
    drawingRequestBall = '0;
    clearMask          = 1'b0;
    test_reset();
    test_pre_sof();
    test_threshold();
    test_no_repeat_scratch();
    test_multi_and_clear();
    test_clear_vs_eval();
    test_saturation();
    test_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
